// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr read-modify-write, trap CSRs, 64-bit cycle/instret counters.
// Trap entry and mret are applied atomically and take priority over a CSR write in the same cycle.
module csr_unit #(
    parameter int          XLEN     = 32,
    parameter int          HART_ID  = 0,
    parameter logic [31:0] MISA_VAL = 32'h40000100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [19:0]     instr_31_12,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd,
    output logic            illegal,
    input  logic            retire,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic [11:0] addr;
    logic [4:0]  field;
    logic [2:0]  funct3;

    assign addr   = instr_31_12[19:8];
    assign field  = instr_31_12[7:3];
    assign funct3 = instr_31_12[2:0];

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] operand, old_val, new_val;
    logic            addr_ok, wr_intent, do_write;

    always_comb begin
        addr_ok = 1'b1;
        old_val = '0;
        case (addr)
            A_MSTATUS:   old_val = XLEN'({mpie_q, 3'b000, mie_q, 3'b000});
            A_MISA:      old_val = XLEN'(MISA_VAL);
            A_MTVEC:     old_val = mtvec_q;
            A_MSCRATCH:  old_val = mscratch_q;
            A_MEPC:      old_val = mepc_q;
            A_MCAUSE:    old_val = mcause_q;
            A_MCYCLE:    old_val = mcycle_q[XLEN-1:0];
            A_MINSTRET:  old_val = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);
                else            addr_ok = 1'b0;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]);
                else            addr_ok = 1'b0;
            end
            A_MHARTID:   old_val = XLEN'(HART_ID);
            default:     addr_ok = 1'b0;
        endcase
    end

    assign operand   = funct3[2] ? XLEN'(field) : wd;
    // RS/RC with a zero source field is a pure read, which keeps mhartid readable.
    assign wr_intent = (funct3[1:0] == 2'b01) || (field != 5'd0);
    assign illegal   = we && (!addr_ok || (funct3[1:0] == 2'b00) ||
                              ((addr[11:10] == 2'b11) && wr_intent));
    assign rd        = illegal ? '0 : old_val;
    assign do_write  = we && !illegal && wr_intent && !trap && !mret;

    always_comb begin
        case (funct3[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_val | operand;
            default: new_val = old_val & ~operand;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = retire ? minstret_q + 64'd1 : minstret_q;

        if (do_write) begin
            case (addr)
                A_MSTATUS: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                A_MTVEC:     mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                A_MSCRATCH:  mscratch_d = new_val;
                A_MEPC:      mepc_d     = {new_val[XLEN-1:2], 2'b00};
                A_MCAUSE:    mcause_d   = new_val;
                // A written half replaces the increment for that cycle; the other half holds.
                A_MCYCLE:    mcycle_d   = (XLEN == 32) ? {mcycle_q[63:32], new_val[31:0]}
                                                       : 64'(new_val);
                A_MINSTRET:  minstret_d = (XLEN == 32) ? {minstret_q[63:32], new_val[31:0]}
                                                       : 64'(new_val);
                A_MCYCLEH:   mcycle_d   = {new_val[31:0], mcycle_q[31:0]};
                A_MINSTRETH: minstret_d = {new_val[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end

        if (trap) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule
